// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router datapath.
// Byte width and destination address codes carried in header bits [1:0].
package router_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ADDR0    = 2'b00;
    localparam logic [1:0] ADDR1    = 2'b01;
    localparam logic [1:0] ADDR2    = 2'b10;
    localparam logic [1:0] ADDR_INV = 2'b11;

endpackage

// File: rtl/router_reg.sv
// Router datapath register stage: header capture, FIFO byte stream,
// full-hold byte and running parity check against the trailing byte.
module router_reg #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err
);

    import router_pkg::*;

    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] int_par_q, int_par_d;
    logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              parity_done_q, parity_done_d;
    logic              lpv_q, lpv_d;
    logic              err_q, err_d;

    logic hdr_ok;
    logic ld_take;
    logic ld_park;
    logic laf_par;
    logic par_mismatch;

    assign hdr_ok  = detect_add && packet_valid
                     && (data_in[1:0] != ADDR_INV);
    assign ld_take = ld_state && !fifo_full;
    assign ld_park = ld_state && fifo_full;
    // A parked parity byte is released once, on the first laf cycle.
    assign laf_par = laf_state && lpv_q && !parity_done_q;

    assign par_mismatch = (int_par_q != pkt_par_q);

    always_comb begin
        hdr_d         = hdr_q;
        hold_d        = hold_q;
        int_par_d     = int_par_q;
        pkt_par_d     = pkt_par_q;
        dout_d        = dout_q;
        parity_done_d = parity_done_q;
        lpv_d         = lpv_q;
        err_d         = err_q;

        if (!full_state) begin
            if (hdr_ok) begin
                hdr_d = data_in;
            end

            if (detect_add) begin
                int_par_d = '0;
            end else if (lfd_state) begin
                int_par_d = int_par_q ^ hdr_q;
            end else if (ld_take && packet_valid) begin
                int_par_d = int_par_q ^ data_in;
            end else if (laf_state && !lpv_q) begin
                int_par_d = int_par_q ^ hold_q;
            end

            if (detect_add) begin
                parity_done_d = 1'b0;
            end else if (ld_take && !packet_valid) begin
                parity_done_d = 1'b1;
            end else if (laf_par) begin
                parity_done_d = 1'b1;
            end

            if (ld_take && !packet_valid) begin
                pkt_par_d = data_in;
            end else if (laf_par) begin
                pkt_par_d = hold_q;
            end

            if (lfd_state) begin
                dout_d = hdr_q;
            end else if (ld_take) begin
                dout_d = data_in;
            end else if (laf_state) begin
                dout_d = hold_q;
            end

            if (ld_park) begin
                hold_d = data_in;
            end

            if (ld_state && !packet_valid) begin
                lpv_d = 1'b1;
            end else if (rst_int_reg) begin
                lpv_d = 1'b0;
            end

            // err holds from check_parity_error until the next first byte.
            if (rst_int_reg) begin
                err_d = par_mismatch;
            end else if (lfd_state) begin
                err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hdr_q         <= '0;
            hold_q        <= '0;
            int_par_q     <= '0;
            pkt_par_q     <= '0;
            dout_q        <= '0;
            parity_done_q <= 1'b0;
            lpv_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            hdr_q         <= hdr_d;
            hold_q        <= hold_d;
            int_par_q     <= int_par_d;
            pkt_par_q     <= pkt_par_d;
            dout_q        <= dout_d;
            parity_done_q <= parity_done_d;
            lpv_q         <= lpv_d;
            err_q         <= err_d;
        end
    end

    assign dout             = dout_q;
    assign parity_done      = parity_done_q;
    assign low_packet_valid = lpv_q;
    assign err              = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: directed packets plus randomized
// packets checked against a packet-level parity and byte-order model.
module tb_router_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         resetn;
    logic         packet_valid;
    logic [W-1:0] data_in;
    logic         fifo_full;
    logic         detect_add;
    logic         lfd_state;
    logic         ld_state;
    logic         laf_state;
    logic         full_state;
    logic         rst_int_reg;
    logic [W-1:0] dout;
    logic         parity_done;
    logic         low_packet_valid;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] pl [0:15];
    bit           fl [0:16];
    int           plen;

    router_reg #(.DATA_W(W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .packet_valid     (packet_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        packet_valid = 1'b0;
        data_in      = '0;
        fifo_full    = 1'b0;
        detect_add   = 1'b0;
        lfd_state    = 1'b0;
        ld_state     = 1'b0;
        laf_state    = 1'b0;
        full_state   = 1'b0;
        rst_int_reg  = 1'b0;
    endtask

    task automatic clear_full();
        for (int i = 0; i < 17; i++) fl[i] = 1'b0;
    endtask

    // Walks one packet through the FSM state sequence; the model is the
    // packet itself: expected parity is the XOR of header and payload.
    task automatic send_packet(input logic [W-1:0] hdr,
                               input logic [W-1:0] par);
        logic [W-1:0] acc;
        logic [W-1:0] exp_dout;
        logic [W-1:0] b;
        logic         exp_err;
        bit           pv;
        acc = hdr;
        for (int i = 0; i < plen; i++) acc = acc ^ pl[i];
        exp_err = (acc != par);

        idle();
        detect_add   = 1'b1;
        packet_valid = 1'b1;
        data_in      = hdr;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        data_in    = 8'($urandom);
        tick();
        checks++;
        if (dout !== hdr) begin
            errors++;
            $display("FAIL lfd_dout: got %h want %h", dout, hdr);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL lfd_err_clear: got %b want 0", err);
        end
        exp_dout  = hdr;
        lfd_state = 1'b0;

        for (int i = 0; i <= plen; i++) begin
            pv           = (i < plen);
            b            = pv ? pl[i] : par;
            ld_state     = 1'b1;
            packet_valid = pv;
            data_in      = b;
            fifo_full    = fl[i];
            tick();
            if (!fl[i]) begin
                exp_dout = b;
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL ld_dout[%0d]: got %h want %h",
                             i, dout, exp_dout);
                end
            end else begin
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL full_dout_hold[%0d]: got %h want %h",
                             i, dout, exp_dout);
                end
                ld_state   = 1'b0;
                full_state = 1'b1;
                data_in    = 8'($urandom);
                tick();
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL full_state_dout[%0d]: got %h want %h",
                             i, dout, exp_dout);
                end
                if (!pv) begin
                    checks++;
                    if (parity_done !== 1'b0 || low_packet_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL full_par_flags: pd=%b lpv=%b want 0 1",
                                 parity_done, low_packet_valid);
                    end
                end
                full_state = 1'b0;
                fifo_full  = 1'b0;
                laf_state  = 1'b1;
                tick();
                exp_dout = b;
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL laf_dout[%0d]: got %h want %h",
                             i, dout, exp_dout);
                end
                laf_state = 1'b0;
            end
            if (!pv) begin
                checks++;
                if (parity_done !== 1'b1 || low_packet_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL par_flags: pd=%b lpv=%b want 1 1",
                             parity_done, low_packet_valid);
                end
            end
        end

        idle();
        rst_int_reg = 1'b1;
        tick();
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err: got %b want %b (hdr %h par %h)",
                     err, exp_err, hdr, par);
        end
        checks++;
        if (low_packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL lpv_clear: got %b want 0", low_packet_valid);
        end
        idle();
        tick();
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_hold: got %b want %b", err, exp_err);
        end
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        #3;
        checks++;
        if (dout !== '0 || parity_done !== 1'b0 ||
            low_packet_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: dout=%h pd=%b lpv=%b err=%b want all 0",
                     dout, parity_done, low_packet_valid, err);
        end
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_clean();
        clear_full();
        plen  = 2;
        pl[0] = 8'hA1;
        pl[1] = 8'h3C;
        send_packet(8'h05, 8'h98);
    endtask

    task automatic test_bad_parity();
        clear_full();
        plen  = 2;
        pl[0] = 8'hA1;
        pl[1] = 8'h3C;
        send_packet(8'h05, 8'h99);
        idle();
        detect_add   = 1'b1;
        packet_valid = 1'b1;
        data_in      = 8'h06;
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_before_lfd: got %b want 1", err);
        end
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_after_lfd: got %b want 0", err);
        end
        idle();
        tick();
    endtask

    task automatic test_full_mid();
        clear_full();
        plen  = 2;
        pl[0] = 8'hA1;
        pl[1] = 8'h3C;
        fl[1] = 1'b1;
        send_packet(8'h05, 8'h98);
    endtask

    task automatic test_full_parity();
        clear_full();
        plen  = 2;
        pl[0] = 8'hA1;
        pl[1] = 8'h3C;
        fl[2] = 1'b1;
        send_packet(8'h05, 8'h98);
        fl[1] = 1'b1;
        send_packet(8'h05, 8'h97);
    endtask

    task automatic test_invalid_addr();
        clear_full();
        plen  = 1;
        pl[0] = 8'h11;
        send_packet(8'h05, 8'h14);
        idle();
        detect_add   = 1'b1;
        packet_valid = 1'b1;
        data_in      = 8'h07;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        checks++;
        if (dout !== 8'h05) begin
            errors++;
            $display("FAIL invalid_addr_hdr: got %h want 05", dout);
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        idle();
        detect_add   = 1'b1;
        packet_valid = 1'b1;
        data_in      = 8'h06;
        tick();
        detect_add = 1'b0;
        lfd_state  = 1'b1;
        tick();
        lfd_state = 1'b0;
        ld_state  = 1'b1;
        data_in   = 8'h5A;
        tick();
        packet_valid = 1'b0;
        data_in      = 8'hC3;
        tick();
        idle();
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (dout !== '0 || parity_done !== 1'b0 ||
            low_packet_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: dout=%h pd=%b lpv=%b err=%b want all 0",
                     dout, parity_done, low_packet_valid, err);
        end
        tick();
        resetn = 1'b1;
        tick();
        clear_full();
        plen  = 3;
        pl[0] = 8'h12;
        pl[1] = 8'h34;
        pl[2] = 8'h56;
        send_packet(8'h02, 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'h56);
        send_packet(8'h02, 8'hFF);
    endtask

    task automatic test_random();
        logic [W-1:0] hdr;
        logic [W-1:0] par;
        for (int n = 0; n < 40; n++) begin
            hdr      = 8'($urandom);
            hdr[1:0] = 2'($urandom_range(0, 2));
            plen     = $urandom_range(1, 8);
            par      = hdr;
            for (int i = 0; i < plen; i++) begin
                pl[i] = 8'($urandom);
                par   = par ^ pl[i];
            end
            for (int i = 0; i <= plen; i++) fl[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) par = par ^ 8'($urandom_range(1, 255));
            send_packet(hdr, par);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bad_parity();
        test_full_mid();
        test_full_parity();
        test_invalid_addr();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
